c1541_track_builder: RTL and testbench

//  Upstream stage of c1541_gcr. On a track change, fetches D64 sector bytes through a request/ack port and
//  GCR-encodes them into a full track image in track RAM: sync, header, gaps, data blocks, tail fill.

---
 rtl/c1541_track_builder_if.sv | 21 ++
 rtl/c1541_track_builder.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_c1541_track_builder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c1541_track_builder_if.sv
// rtl/c1541_track_builder_if.sv - sector fetch and track RAM write bus of c1541_track_builder
interface c1541_track_builder_if;
    logic        sd_req;
    logic [12:0] sd_addr;
    logic        sd_ack;
    logic [7:0]  sd_data;
    logic        sec_err;
    logic [12:0] ram_addr;
    logic [7:0]  ram_di;
    logic        ram_we;

    modport master (
        output sd_req, sd_addr, ram_addr, ram_di, ram_we,
        input  sd_ack, sd_data, sec_err
    );

    modport slave (
        input  sd_req, sd_addr, ram_addr, ram_di, ram_we,
        output sd_ack, sd_data, sec_err
    );
endinterface

// File: rtl/c1541_track_builder.sv
// rtl/c1541_track_builder.sv - builds a GCR track image in track RAM from D64 sectors (option macro: C1541_BAD_SECTOR_EN)
module c1541_track_builder #(
    parameter int SYNC_LEN    = 5,
    parameter int HDR_GAP_LEN = 9,
    parameter int GAP_LEN     = 8
) (
    input  logic                  clk32,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [5:0]            track,
    input  logic [15:0]           disk_id,
    c1541_track_builder_if.master bus,
    output logic [1:0]            speed_zone,
    output logic                  track_ready,
    output logic                  build_err
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_SYNC1, ST_HDR, ST_HGAP, ST_SYNC2, ST_DATA, ST_GAP, ST_FILL, ST_DONE
    } state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);
    localparam logic [3:0] HGAP_LAST = 4'(HDR_GAP_LEN - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_LEN - 1);

    function automatic logic [4:0] gcr_nib(input logic [3:0] n);
        case (n)
            4'h0: return 5'h0A;
            4'h1: return 5'h0B;
            4'h2: return 5'h12;
            4'h3: return 5'h13;
            4'h4: return 5'h0E;
            4'h5: return 5'h0F;
            4'h6: return 5'h16;
            4'h7: return 5'h17;
            4'h8: return 5'h09;
            4'h9: return 5'h19;
            4'hA: return 5'h1A;
            4'hB: return 5'h1B;
            4'hC: return 5'h0D;
            4'hD: return 5'h1D;
            4'hE: return 5'h1E;
            default: return 5'h15;
        endcase
    endfunction

    function automatic logic [1:0] zone_of(input logic [5:0] t);
        if (t <= 6'd17)      return 2'd3;
        else if (t <= 6'd24) return 2'd2;
        else if (t <= 6'd30) return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [12:0] last_addr(input logic [1:0] z);
        case (z)
            2'd3:    return 13'd7691;
            2'd2:    return 13'd7141;
            2'd1:    return 13'd6665;
            default: return 13'd6249;
        endcase
    endfunction

    function automatic logic [4:0] last_sec(input logic [1:0] z);
        case (z)
            2'd3:    return 5'd20;
            2'd2:    return 5'd18;
            2'd1:    return 5'd17;
            default: return 5'd16;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  track_q, track_d;
    logic [15:0] id_q, id_d;
    logic [1:0]  zone_q, zone_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [4:0]  sector_q, sector_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  idx_q, idx_d;
    logic [2:0]  gcnt_q, gcnt_d;
    logic [2:0]  ecnt_q, ecnt_d;
    logic [31:0] grp_q, grp_d;
    logic [7:0]  dcs_q, dcs_d;
    logic        bad_q, bad_d;
    logic        req_q, req_d;
    logic [12:0] saddr_q, saddr_d;
    logic [12:0] wptr_q, wptr_d;
    logic [12:0] raddr_q, raddr_d;
    logic [7:0]  rdi_q, rdi_d;
    logic        rwe_q, rwe_d;

    logic        wr_en;
    logic [7:0]  wr_byte;
    logic        raw_ok;
    logic [7:0]  raw_byte;
    logic        is_dbyte;
    logic [7:0]  hdr_cs;
    logic [39:0] gcr40;
    logic [7:0]  gcr_byte;

    assign hdr_cs = {3'b000, sector_q} ^ {2'b00, track_q} ^ id_q[15:8] ^ id_q[7:0];
    assign gcr40  = {gcr_nib(grp_q[31:28]), gcr_nib(grp_q[27:24]), gcr_nib(grp_q[23:20]),
                     gcr_nib(grp_q[19:16]), gcr_nib(grp_q[15:12]), gcr_nib(grp_q[11:8]),
                     gcr_nib(grp_q[7:4]),   gcr_nib(grp_q[3:0])};

    always_comb begin
        case (ecnt_q)
            3'd0:    gcr_byte = gcr40[39:32];
            3'd1:    gcr_byte = gcr40[31:24];
            3'd2:    gcr_byte = gcr40[23:16];
            3'd3:    gcr_byte = gcr40[15:8];
            default: gcr_byte = gcr40[7:0];
        endcase
    end

    // Raw byte feeding the current 4-byte group; data bytes only exist in the ack cycle.
    always_comb begin
        raw_ok   = 1'b0;
        raw_byte = 8'h00;
        is_dbyte = 1'b0;
        if (state_q == ST_HDR) begin
            raw_ok = 1'b1;
            case (idx_q[2:0])
                3'd0:    raw_byte = 8'h08;
                3'd1:    raw_byte = hdr_cs;
                3'd2:    raw_byte = {3'b000, sector_q};
                3'd3:    raw_byte = {2'b00, track_q};
                3'd4:    raw_byte = id_q[15:8];
                3'd5:    raw_byte = id_q[7:0];
                default: raw_byte = 8'h0F;
            endcase
        end else if (state_q == ST_DATA) begin
            if (idx_q == 9'd0) begin
                raw_ok   = 1'b1;
                raw_byte = 8'h07;
            end else if (idx_q <= 9'd256) begin
                is_dbyte = 1'b1;
                raw_ok   = req_q & bus.sd_ack;
                raw_byte = bus.sd_data;
            end else if (idx_q == 9'd257) begin
                raw_ok   = 1'b1;
                raw_byte = bad_q ? ~dcs_q : dcs_q;
            end else begin
                raw_ok   = 1'b1;
                raw_byte = 8'h00;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        track_d  = track_q;
        id_d     = id_q;
        zone_d   = zone_q;
        ready_d  = ready_q;
        err_d    = 1'b0;
        sector_d = sector_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        gcnt_d   = gcnt_q;
        ecnt_d   = ecnt_q;
        grp_d    = grp_q;
        dcs_d    = dcs_q;
        bad_d    = bad_q;
        req_d    = req_q;
        saddr_d  = saddr_q;
        wptr_d   = wptr_q;
        raddr_d  = raddr_q;
        rdi_d    = rdi_q;
        rwe_d    = 1'b0;
        wr_en    = 1'b0;
        wr_byte  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (track == 6'd0 || track > 6'd42) begin
                        err_d = 1'b1;
                    end else begin
                        track_d  = track;
                        id_d     = disk_id;
                        zone_d   = zone_of(track);
                        ready_d  = 1'b0;
                        sector_d = 5'd0;
                        cnt_d    = 4'd0;
                        wptr_d   = 13'd0;
                        state_d  = ST_SYNC1;
                    end
                end
            end
            ST_SYNC1, ST_SYNC2: begin
                wr_en   = 1'b1;
                wr_byte = 8'hFF;
                if (cnt_q == SYNC_LAST) begin
                    cnt_d  = 4'd0;
                    idx_d  = 9'd0;
                    gcnt_d = 3'd0;
                    ecnt_d = 3'd0;
                    if (state_q == ST_SYNC1) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_DATA;
                        dcs_d   = 8'h00;
`ifdef C1541_BAD_SECTOR_EN
                        bad_d   = bus.sec_err;
`else
                        bad_d   = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HDR, ST_DATA: begin
                if (gcnt_q == 3'd4) begin
                    wr_en   = 1'b1;
                    wr_byte = gcr_byte;
                    if (ecnt_q == 3'd4) begin
                        ecnt_d = 3'd0;
                        gcnt_d = 3'd0;
                        if (state_q == ST_HDR && idx_q == 9'd8) begin
                            state_d = ST_HGAP;
                            cnt_d   = 4'd0;
                        end else if (state_q == ST_DATA && idx_q == 9'd260) begin
                            state_d = ST_GAP;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        ecnt_d = ecnt_q + 3'd1;
                    end
                end else begin
                    if (raw_ok) begin
                        grp_d  = {grp_q[23:0], raw_byte};
                        gcnt_d = gcnt_q + 3'd1;
                        idx_d  = idx_q + 9'd1;
                        if (is_dbyte) dcs_d = dcs_q ^ raw_byte;
                    end
                    // One request in flight; req is low for a cycle between bytes.
                    if (is_dbyte) begin
                        if (req_q && bus.sd_ack) begin
                            req_d = 1'b0;
                        end else if (!req_q) begin
                            req_d   = 1'b1;
                            saddr_d = {sector_q, idx_q[7:0] - 8'd1};
                        end
                    end
                end
            end
            ST_HGAP: begin
                wr_en   = 1'b1;
                wr_byte = 8'h55;
                if (cnt_q == HGAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_SYNC2;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                wr_en   = 1'b1;
                wr_byte = 8'h55;
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 4'd0;
                    if (sector_q == last_sec(zone_q)) begin
                        state_d = ST_FILL;
                    end else begin
                        sector_d = sector_q + 5'd1;
                        state_d  = ST_SYNC1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_FILL: begin
                wr_en   = (wptr_q <= last_addr(zone_q));
                wr_byte = 8'h55;
                if (wptr_q >= last_addr(zone_q)) state_d = ST_DONE;
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_en) begin
            rwe_d   = 1'b1;
            rdi_d   = wr_byte;
            raddr_d = wptr_q;
            wptr_d  = wptr_q + 13'd1;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            track_q  <= 6'd0;
            id_q     <= 16'd0;
            zone_q   <= 2'd0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            sector_q <= 5'd0;
            cnt_q    <= 4'd0;
            idx_q    <= 9'd0;
            gcnt_q   <= 3'd0;
            ecnt_q   <= 3'd0;
            grp_q    <= 32'd0;
            dcs_q    <= 8'd0;
            bad_q    <= 1'b0;
            req_q    <= 1'b0;
            saddr_q  <= 13'd0;
            wptr_q   <= 13'd0;
            raddr_q  <= 13'd0;
            rdi_q    <= 8'd0;
            rwe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            track_q  <= track_d;
            id_q     <= id_d;
            zone_q   <= zone_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            sector_q <= sector_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            gcnt_q   <= gcnt_d;
            ecnt_q   <= ecnt_d;
            grp_q    <= grp_d;
            dcs_q    <= dcs_d;
            bad_q    <= bad_d;
            req_q    <= req_d;
            saddr_q  <= saddr_d;
            wptr_q   <= wptr_d;
            raddr_q  <= raddr_d;
            rdi_q    <= rdi_d;
            rwe_q    <= rwe_d;
        end
    end

    assign bus.sd_req   = req_q;
    assign bus.sd_addr  = saddr_q;
    assign bus.ram_addr = raddr_q;
    assign bus.ram_di   = rdi_q;
    assign bus.ram_we   = rwe_q;
    assign speed_zone   = zone_q;
    assign track_ready  = ready_q;
    assign build_err    = err_q;
endmodule

// File: tb/tb_c1541_track_builder.sv
// tb/tb_c1541_track_builder.sv - scoreboard bench for c1541_track_builder
module tb_c1541_track_builder;
    logic        clk32 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  track = 6'd0;
    logic [15:0] disk_id = 16'd0;
    logic [1:0]  speed_zone;
    logic        track_ready;
    logic        build_err;

    c1541_track_builder_if bus();

    c1541_track_builder dut (
        .clk32       (clk32),
        .reset_n     (reset_n),
        .start       (start),
        .track       (track),
        .disk_id     (disk_id),
        .bus         (bus),
        .speed_zone  (speed_zone),
        .track_ready (track_ready),
        .build_err   (build_err)
    );

    always #5 clk32 = ~clk32;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [4:0] gcr_tbl [16] = '{5'h0A, 5'h0B, 5'h12, 5'h13, 5'h0E, 5'h0F, 5'h16, 5'h17,
                                 5'h09, 5'h19, 5'h1A, 5'h1B, 5'h0D, 5'h1D, 5'h1E, 5'h15};

    logic [20:0] exp_q [$];
    int gen_addr, bitacc, nbits;
    int cur_trk = 1;
    int pat_seed = 0;
    bit zero_sec0 = 1'b0;
    int ack_delay = 0;
    int proto_err = 0;
    int wr_cnt = 0;
    int extra_wr = 0;
    bit sec_err_en = 1'b0;
    logic [12:0] last_wr_addr = 13'd0;
    logic [7:0]  cap [10];

    function automatic logic [7:0] sd_byte(input int trk, input int sec, input int off);
        if (zero_sec0 && sec == 0) return 8'h00;
        return 8'((trk * 37) + (sec * 11) + (off * 3) + (off >> 3) + pat_seed);
    endfunction

    function automatic int exp_zone(input int trk);
        if (trk <= 17) return 3;
        if (trk <= 24) return 2;
        if (trk <= 30) return 1;
        return 0;
    endfunction

    task automatic put(input logic [7:0] b);
        exp_q.push_back({13'(gen_addr), b});
        gen_addr++;
    endtask

    task automatic put_raw(input logic [7:0] b);
        logic [3:0] n;
        for (int h = 1; h >= 0; h--) begin
            n = (h == 1) ? b[7:4] : b[3:0];
            bitacc = (bitacc << 5) | int'(gcr_tbl[n]);
            nbits += 5;
            if (nbits >= 8) begin
                nbits -= 8;
                put(8'(bitacc >> nbits));
                bitacc = bitacc & ((1 << nbits) - 1);
            end
        end
    endtask

    task automatic gen_track(input int trk, input logic [15:0] id, input int bad_sec);
        int nsec, len;
        logic [7:0] cs, dcs, d;
        nsec = (trk <= 17) ? 21 : (trk <= 24) ? 19 : (trk <= 30) ? 18 : 17;
        len  = (trk <= 17) ? 7692 : (trk <= 24) ? 7142 : (trk <= 30) ? 6666 : 6250;
        gen_addr = 0; bitacc = 0; nbits = 0;
        for (int s = 0; s < nsec; s++) begin
            repeat (5) put(8'hFF);
            cs = 8'(s) ^ 8'(trk) ^ id[15:8] ^ id[7:0];
            put_raw(8'h08); put_raw(cs); put_raw(8'(s)); put_raw(8'(trk));
            put_raw(id[15:8]); put_raw(id[7:0]); put_raw(8'h0F); put_raw(8'h0F);
            repeat (9) put(8'h55);
            repeat (5) put(8'hFF);
            put_raw(8'h07);
            dcs = 8'h00;
            for (int i = 0; i < 256; i++) begin
                d = sd_byte(trk, s, i);
                put_raw(d);
                dcs ^= d;
            end
            put_raw((s == bad_sec) ? ~dcs : dcs);
            put_raw(8'h00); put_raw(8'h00);
            repeat (8) put(8'h55);
        end
        while (gen_addr < len) put(8'h55);
    endtask

    // Sector-store model: answers each request after ack_delay extra cycles.
    initial begin
        int wait_cnt;
        logic [12:0] req_addr;
        wait_cnt = 0;
        req_addr = 13'd0;
        bus.sd_ack  = 1'b0;
        bus.sd_data = 8'h00;
        forever begin
            @(posedge clk32);
            #1;
            if (!reset_n) begin
                bus.sd_ack = 1'b0;
                wait_cnt = 0;
            end else if (bus.sd_ack) begin
                bus.sd_ack = 1'b0;
                if (bus.sd_req) proto_err++;
            end else if (bus.sd_req) begin
                if (wait_cnt == 0) req_addr = bus.sd_addr;
                else if (bus.sd_addr != req_addr) proto_err++;
                if (wait_cnt >= ack_delay) begin
                    bus.sd_ack  = 1'b1;
                    bus.sd_data = sd_byte(cur_trk, int'(req_addr[12:8]), int'(req_addr[7:0]));
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (wait_cnt != 0) begin
                proto_err++;
                wait_cnt = 0;
            end
        end
    end

    // Write monitor: pops the scoreboard on every RAM strobe and drives sec_err for sector 3.
    initial begin
        bus.sec_err = 1'b0;
        forever begin
            @(negedge clk32);
            if (bus.ram_we === 1'b1) begin
                if (wr_cnt < 10) cap[wr_cnt] = bus.ram_di;
                last_wr_addr = bus.ram_addr;
                wr_cnt++;
                if (exp_q.size() == 0) extra_wr++;
                else check("wr", {11'd0, bus.ram_addr, bus.ram_di}, {11'd0, exp_q.pop_front()});
            end
            bus.sec_err = sec_err_en && ((wr_cnt / 362) == 3);
        end
    end

    task automatic start_build(input int trk, input logic [15:0] id, input int bad_sec);
        exp_q.delete();
        gen_track(trk, id, bad_sec);
        cur_trk  = trk;
        wr_cnt   = 0;
        extra_wr = 0;
        @(negedge clk32);
        start = 1'b1; track = 6'(trk); disk_id = id;
        @(negedge clk32);
        start = 1'b0;
        #1;
        check("zone", 32'(speed_zone), 32'(exp_zone(trk)));
        check("rdy_low", 32'(track_ready), 32'd0);
    endtask

    task automatic wait_done(input int len);
        for (int i = 0; i < 60000 && exp_q.size() != 0; i++) begin
            @(negedge clk32);
            #1;
        end
        check("left", 32'(exp_q.size()), 32'd0);
        check("last_addr", 32'(last_wr_addr), 32'(len - 1));
        check("rdy_pre", 32'(track_ready), 32'd0);
        @(negedge clk32);
        #1;
        check("rdy_post", 32'(track_ready), 32'd1);
        check("extra_wr", 32'(extra_wr), 32'd0);
        check("proto", 32'(proto_err), 32'd0);
    endtask

    task automatic illegal_start(input logic [5:0] t);
        extra_wr = 0;
        @(negedge clk32);
        start = 1'b1; track = t;
        @(negedge clk32);
        start = 1'b0;
        #1;
        check("err_pulse", 32'(build_err), 32'd1);
        @(negedge clk32);
        #1;
        check("err_clear", 32'(build_err), 32'd0);
        check("err_rdy", 32'(track_ready), 32'd1);
        check("err_zone", 32'(speed_zone), 32'd3);
        repeat (5) @(negedge clk32);
        check("err_wr", 32'(extra_wr), 32'd0);
    endtask

    initial begin
        bit found;
        int bad_exp;
        repeat (3) @(negedge clk32);
        #1;
        check("rst_sd", {18'd0, bus.sd_req, bus.sd_addr}, 32'd0);
        check("rst_ram", {10'd0, bus.ram_addr, bus.ram_di, bus.ram_we}, 32'd0);
        check("rst_misc", {28'd0, speed_zone, track_ready, build_err}, 32'd0);
        reset_n = 1'b1;

        // Stray ack while idle must not cause any activity.
        @(negedge clk32);
        bus.sd_ack = 1'b1;
        @(negedge clk32);
        bus.sd_ack = 1'b0;

        zero_sec0 = 1'b1; pat_seed = 5; ack_delay = 0;
        start_build(1, 16'h4241, -1);
        repeat (50) @(negedge clk32);
        start = 1'b1; track = 6'd35; disk_id = 16'h0000;
        @(negedge clk32);
        start = 1'b0;
        wait_done(7692);
        for (int i = 0; i < 5; i++) check("sync0", 32'(cap[i]), 32'hFF);
        check("hdr0", 32'(cap[5]), 32'h52);
        check("hdr1", 32'(cap[6]), 32'h55);
        check("hdr2", 32'(cap[7]), 32'h25);
        check("hdr3", 32'(cap[8]), 32'h29);
        check("hdr4", 32'(cap[9]), 32'h4B);

        illegal_start(6'd0);
        illegal_start(6'd43);

        // Slow sector store, then reset in the middle of sector 5's data block.
        zero_sec0 = 1'b0; pat_seed = 9; ack_delay = 20;
        start_build(35, 16'h3030, -1);
        found = 1'b0;
        for (int i = 0; i < 40000 && !found; i++) begin
            @(negedge clk32);
            #1;
            if (bus.sd_req && bus.sd_addr == {5'd5, 8'd40}) found = 1'b1;
        end
        check("reach_s5", 32'(found), 32'd1);
        check("wr_s5", 32'(wr_cnt), 32'd1889);
        check("proto_slow", 32'(proto_err), 32'd0);
        check("extra_slow", 32'(extra_wr), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_sd", {18'd0, bus.sd_req, bus.sd_addr}, 32'd0);
        check("arst_ram", {10'd0, bus.ram_addr, bus.ram_di, bus.ram_we}, 32'd0);
        check("arst_misc", {28'd0, speed_zone, track_ready, build_err}, 32'd0);
        exp_q.delete();
        @(negedge clk32);
        @(negedge clk32);
        reset_n = 1'b1;

`ifdef C1541_BAD_SECTOR_EN
        bad_exp = 3;
`else
        bad_exp = -1;
`endif
        ack_delay = 0; sec_err_en = 1'b1;
        start_build(35, 16'h3030, bad_exp);
        wait_done(6250);
        sec_err_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
